// File: rtl/irq_trap_ctrl_if.sv
// Bundle between irq_trap_ctrl and csrfile.
// master = trap sequencer (drives strobes), slave = csrfile (drives state).
interface irq_trap_ctrl_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  mip_external_i;
    logic                  mip_timer_i;
    logic                  mip_software_i;
    logic                  mie_external_i;
    logic                  mie_timer_i;
    logic                  mie_software_i;
    logic                  mstatus_ie_i;
    logic [DATA_WIDTH-1:0] mtvec_i;
    logic [DATA_WIDTH-1:0] epc_i;
    logic                  cause_we_o;
    logic                  interrupt_type_o;
    logic [3:0]            cause_o;
    logic                  epc_we_o;
    logic [DATA_WIDTH-1:0] epc_o;
    logic                  mstatus_ie_clear_o;
    logic                  mstatus_ie_set_o;

    modport master (
        input  mip_external_i, mip_timer_i, mip_software_i,
        input  mie_external_i, mie_timer_i, mie_software_i,
        input  mstatus_ie_i, mtvec_i, epc_i,
        output cause_we_o, interrupt_type_o, cause_o,
        output epc_we_o, epc_o,
        output mstatus_ie_clear_o, mstatus_ie_set_o
    );

    modport slave (
        output mip_external_i, mip_timer_i, mip_software_i,
        output mie_external_i, mie_timer_i, mie_software_i,
        output mstatus_ie_i, mtvec_i, epc_i,
        input  cause_we_o, interrupt_type_o, cause_o,
        input  epc_we_o, epc_o,
        input  mstatus_ie_clear_o, mstatus_ie_set_o
    );
endinterface

// File: rtl/irq_trap_ctrl.sv
// Trap/interrupt sequencer: detects ecall/ebreak/mret/interrupts at EX,
// drives csrfile strobes (csr bundle), and stalls/flushes/redirects the pipe.
module irq_trap_ctrl #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  inst_valid_i,
    input  logic [DATA_WIDTH-1:0] inst_pc_i,
    input  logic                  ecall_i,
    input  logic                  ebreak_i,
    input  logic                  mret_i,
    output logic                  stall_o,
    output logic                  flush_o,
    output logic                  redirect_o,
    output logic [DATA_WIDTH-1:0] redirect_pc_o,
    irq_trap_ctrl_if.master       csr
);

    typedef enum logic [2:0] {
        IDLE,
        TRAP_SAVE,
        TRAP_JUMP,
        MRET_RESTORE,
        MRET_JUMP
    } state_e;

    localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~DATA_WIDTH'(3);

    state_e                state_q, state_d;
    logic [3:0]            cause_q, cause_d;
    logic                  irq_q, irq_d;
    logic [DATA_WIDTH-1:0] epc_q, epc_d;
    logic [DATA_WIDTH-1:0] target_q, target_d;

    logic                  pend_ext, pend_tmr, pend_sw;
    logic                  irq_take;
    logic                  det_trap, det_irq, det_mret;
    logic [3:0]            det_cause;
    logic [DATA_WIDTH-1:0] base;
    logic [DATA_WIDTH-1:0] vec_off;
    logic [DATA_WIDTH-1:0] det_target;

    // Event detection with fixed priority: ecall > ebreak > mret > irq.
    always_comb begin
        pend_ext  = csr.mip_external_i & csr.mie_external_i;
        pend_tmr  = csr.mip_timer_i    & csr.mie_timer_i;
        pend_sw   = csr.mip_software_i & csr.mie_software_i;
        irq_take  = csr.mstatus_ie_i & (pend_ext | pend_tmr | pend_sw);
        det_trap  = 1'b0;
        det_irq   = 1'b0;
        det_mret  = 1'b0;
        det_cause = 4'd0;
        if (inst_valid_i && !rst_i) begin
            if (ecall_i) begin
                det_trap  = 1'b1;
                det_cause = 4'd11;
            end else if (ebreak_i) begin
                det_trap  = 1'b1;
                det_cause = 4'd3;
            end else if (mret_i) begin
                det_mret  = 1'b1;
            end else if (irq_take) begin
                det_trap = 1'b1;
                det_irq  = 1'b1;
                if (pend_ext)     det_cause = 4'd11;
                else if (pend_sw) det_cause = 4'd3;
                else              det_cause = 4'd7;
            end
        end
        // Vectored mode only for interrupts; modes 10/11 fall back to direct.
        base       = csr.mtvec_i & ALIGN_MASK;
        vec_off    = DATA_WIDTH'({det_cause, 2'b00});
        det_target = (csr.mtvec_i[1:0] == 2'b01 && det_irq) ?
                     base + vec_off : base;
    end

    always_comb begin
        state_d                = state_q;
        cause_d                = cause_q;
        irq_d                  = irq_q;
        epc_d                  = epc_q;
        target_d               = target_q;
        stall_o                = 1'b0;
        flush_o                = 1'b0;
        redirect_o             = 1'b0;
        redirect_pc_o          = '0;
        csr.cause_we_o         = 1'b0;
        csr.epc_we_o           = 1'b0;
        csr.mstatus_ie_clear_o = 1'b0;
        csr.mstatus_ie_set_o   = 1'b0;
        case (state_q)
            IDLE: begin
                if (det_trap) begin
                    stall_o  = 1'b1;
                    flush_o  = 1'b1;
                    cause_d  = det_cause;
                    irq_d    = det_irq;
                    epc_d    = inst_pc_i & ALIGN_MASK;
                    target_d = det_target;
                    state_d  = TRAP_SAVE;
                end else if (det_mret) begin
                    stall_o  = 1'b1;
                    flush_o  = 1'b1;
                    state_d  = MRET_RESTORE;
                end
            end
            TRAP_SAVE: begin
                csr.cause_we_o         = 1'b1;
                csr.epc_we_o           = 1'b1;
                csr.mstatus_ie_clear_o = 1'b1;
                stall_o                = 1'b1;
                state_d                = TRAP_JUMP;
            end
            TRAP_JUMP: begin
                redirect_o    = 1'b1;
                redirect_pc_o = target_q;
                state_d       = IDLE;
            end
            // Extra cycle lets a just-issued mepc write land before use.
            MRET_RESTORE: begin
                csr.mstatus_ie_set_o = 1'b1;
                stall_o              = 1'b1;
                state_d              = MRET_JUMP;
            end
            MRET_JUMP: begin
                redirect_o    = 1'b1;
                redirect_pc_o = csr.epc_i & ALIGN_MASK;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign csr.cause_o          = cause_q;
    assign csr.interrupt_type_o = irq_q;
    assign csr.epc_o            = epc_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cause_q  <= 4'd0;
            irq_q    <= 1'b0;
            epc_q    <= '0;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            cause_q  <= cause_d;
            irq_q    <= irq_d;
            epc_q    <= epc_d;
            target_q <= target_d;
        end
    end

endmodule

// File: tb/tb_irq_trap_ctrl.sv
// Self-checking bench for irq_trap_ctrl.
// Scoreboard of expected trap/mret results, popped when the DUT responds.
module tb_irq_trap_ctrl;

    logic        clk;
    logic        rst_i;
    logic        inst_valid_i;
    logic [31:0] inst_pc_i;
    logic        ecall_i;
    logic        ebreak_i;
    logic        mret_i;
    logic        stall_o;
    logic        flush_o;
    logic        redirect_o;
    logic [31:0] redirect_pc_o;

    irq_trap_ctrl_if #(.DATA_WIDTH(32)) csr_if ();

    irq_trap_ctrl #(.DATA_WIDTH(32)) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .inst_valid_i  (inst_valid_i),
        .inst_pc_i     (inst_pc_i),
        .ecall_i       (ecall_i),
        .ebreak_i      (ebreak_i),
        .mret_i        (mret_i),
        .stall_o       (stall_o),
        .flush_o       (flush_o),
        .redirect_o    (redirect_o),
        .redirect_pc_o (redirect_pc_o),
        .csr           (csr_if.master)
    );

    typedef struct {
        logic [3:0]  cause;
        logic        irq;
        logic [31:0] epc;
        logic [31:0] pc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_lines(input logic [2:0] mip, input logic [2:0] mie);
        {csr_if.mip_external_i, csr_if.mip_timer_i,
         csr_if.mip_software_i} = mip;
        {csr_if.mie_external_i, csr_if.mie_timer_i,
         csr_if.mie_software_i} = mie;
    endtask

    task automatic test_reset;
        rst_i        = 1'b1;
        inst_valid_i = 1'b0;
        inst_pc_i    = '0;
        ecall_i      = 1'b0;
        ebreak_i     = 1'b0;
        mret_i       = 1'b0;
        set_lines(3'b000, 3'b000);
        csr_if.mstatus_ie_i = 1'b0;
        csr_if.mtvec_i      = '0;
        csr_if.epc_i        = '0;
        repeat (3) @(negedge clk);
        rst_i = 1'b0;
        #1;
        checks++;
        if ({stall_o, flush_o, redirect_o, redirect_pc_o,
             csr_if.cause_we_o, csr_if.epc_we_o, csr_if.cause_o,
             csr_if.interrupt_type_o, csr_if.epc_o,
             csr_if.mstatus_ie_clear_o, csr_if.mstatus_ie_set_o} !== '0)
            begin
            errors++;
            $display("FAIL reset_outputs: stall=%b flush=%b redir=%b pc=%h cause=%0d epc=%h",
                     stall_o, flush_o, redirect_o, redirect_pc_o,
                     csr_if.cause_o, csr_if.epc_o);
        end
    endtask

    task automatic test_trap(input string nm, input logic [31:0] pc,
                             input logic [31:0] mtvec,
                             input logic [2:0] mip, input logic [2:0] mie,
                             input logic ec, input logic eb,
                             input logic [3:0] ecause, input logic eirq,
                             input logic [31:0] etgt);
        exp_t e;
        bit   seen;
        @(negedge clk);
        csr_if.mtvec_i      = mtvec;
        csr_if.mstatus_ie_i = 1'b1;
        set_lines(mip, mie);
        inst_pc_i    = pc;
        ecall_i      = ec;
        ebreak_i     = eb;
        mret_i       = 1'b0;
        inst_valid_i = 1'b1;
        #1;
        checks++;
        if (stall_o !== 1'b1 || flush_o !== 1'b1 || redirect_o !== 1'b0) begin
            errors++;
            $display("FAIL %s_detect: stall=%b flush=%b redir=%b want 1 1 0",
                     nm, stall_o, flush_o, redirect_o);
        end
        sb.push_back('{ecause, eirq, pc & 32'hFFFF_FFFC, etgt});
        @(negedge clk);
        inst_valid_i = 1'b0;
        ecall_i      = 1'b0;
        ebreak_i     = 1'b0;
        seen = 0;
        for (int i = 0; i < 4 && !seen; i++) begin
            #1;
            if (csr_if.cause_we_o === 1'b1) seen = 1;
            else @(negedge clk);
        end
        e = sb.pop_front();
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_save_timeout: cause_we never seen", nm);
            return;
        end
        checks++;
        if (csr_if.cause_o !== e.cause || csr_if.interrupt_type_o !== e.irq ||
            csr_if.epc_o !== e.epc || csr_if.epc_we_o !== 1'b1 ||
            csr_if.mstatus_ie_clear_o !== 1'b1 || stall_o !== 1'b1 ||
            redirect_o !== 1'b0) begin
            errors++;
            $display("FAIL %s_save: cause=%0d type=%b epc=%h epc_we=%b clr=%b stall=%b want cause=%0d type=%b epc=%h 1 1 1",
                     nm, csr_if.cause_o, csr_if.interrupt_type_o,
                     csr_if.epc_o, csr_if.epc_we_o,
                     csr_if.mstatus_ie_clear_o, stall_o,
                     e.cause, e.irq, e.epc);
        end
        csr_if.mstatus_ie_i = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (redirect_o !== 1'b1 || redirect_pc_o !== e.pc ||
            stall_o !== 1'b0 || csr_if.cause_we_o !== 1'b0 ||
            csr_if.mstatus_ie_clear_o !== 1'b0) begin
            errors++;
            $display("FAIL %s_jump: redir=%b pc=%h stall=%b we=%b want 1 %h 0 0",
                     nm, redirect_o, redirect_pc_o, stall_o,
                     csr_if.cause_we_o, e.pc);
        end
        @(negedge clk);
        #1;
        checks++;
        if (redirect_o !== 1'b0 || flush_o !== 1'b0 ||
            csr_if.cause_o !== e.cause || csr_if.epc_o !== e.epc) begin
            errors++;
            $display("FAIL %s_after: redir=%b flush=%b cause=%0d epc=%h want 0 0 %0d %h",
                     nm, redirect_o, flush_o, csr_if.cause_o, csr_if.epc_o,
                     e.cause, e.epc);
        end
    endtask

    task automatic test_mret;
        logic [31:0] epcs [2];
        exp_t e;
        epcs[0] = 32'h0000_0044;
        epcs[1] = 32'h0000_0047;
        foreach (epcs[k]) begin
            @(negedge clk);
            set_lines(3'b000, 3'b000);
            csr_if.mstatus_ie_i = 1'b0;
            csr_if.epc_i = epcs[k];
            inst_pc_i    = 32'h0000_0200;
            mret_i       = 1'b1;
            inst_valid_i = 1'b1;
            #1;
            checks++;
            if (stall_o !== 1'b1 || flush_o !== 1'b1) begin
                errors++;
                $display("FAIL mret_detect: stall=%b flush=%b want 1 1",
                         stall_o, flush_o);
            end
            sb.push_back('{4'd0, 1'b0, 32'h0, epcs[k] & 32'hFFFF_FFFC});
            @(negedge clk);
            mret_i       = 1'b0;
            inst_valid_i = 1'b0;
            #1;
            checks++;
            if (csr_if.mstatus_ie_set_o !== 1'b1 || stall_o !== 1'b1 ||
                csr_if.cause_we_o !== 1'b0 || redirect_o !== 1'b0) begin
                errors++;
                $display("FAIL mret_restore: set=%b stall=%b we=%b redir=%b want 1 1 0 0",
                         csr_if.mstatus_ie_set_o, stall_o,
                         csr_if.cause_we_o, redirect_o);
            end
            csr_if.mstatus_ie_i = 1'b1;
            @(negedge clk);
            #1;
            e = sb.pop_front();
            checks++;
            if (redirect_o !== 1'b1 || redirect_pc_o !== e.pc ||
                stall_o !== 1'b0 || csr_if.mstatus_ie_set_o !== 1'b0) begin
                errors++;
                $display("FAIL mret_jump: redir=%b pc=%h stall=%b set=%b want 1 %h 0 0",
                         redirect_o, redirect_pc_o, stall_o,
                         csr_if.mstatus_ie_set_o, e.pc);
            end
        end
    endtask

    task automatic test_masking;
        logic [2:0] mips [3];
        logic [2:0] mies [3];
        logic       ies  [3];
        logic       vals [3];
        mips[0] = 3'b010; mies[0] = 3'b010; ies[0] = 1'b0; vals[0] = 1'b1;
        mips[1] = 3'b001; mies[1] = 3'b000; ies[1] = 1'b1; vals[1] = 1'b1;
        mips[2] = 3'b010; mies[2] = 3'b010; ies[2] = 1'b1; vals[2] = 1'b0;
        foreach (mips[k]) begin
            @(negedge clk);
            csr_if.mtvec_i      = 32'h0000_0100;
            csr_if.mstatus_ie_i = ies[k];
            set_lines(mips[k], mies[k]);
            inst_pc_i    = 32'h0000_0060;
            inst_valid_i = vals[k];
            for (int c = 0; c < 20; c++) begin
                #1;
                checks++;
                if (flush_o !== 1'b0 || csr_if.cause_we_o !== 1'b0 ||
                    redirect_o !== 1'b0 || csr_if.epc_we_o !== 1'b0) begin
                    errors++;
                    $display("FAIL mask_%0d cycle %0d: flush=%b we=%b redir=%b want 0",
                             k, c, flush_o, csr_if.cause_we_o, redirect_o);
                end
                @(negedge clk);
            end
        end
        inst_valid_i = 1'b0;
        test_trap("valid_late", 32'h0000_0060, 32'h0000_0100,
                  3'b010, 3'b010, 1'b0, 1'b0, 4'd7, 1'b1, 32'h0000_0100);
    endtask

    task automatic test_reset_mid_trap;
        exp_t e;
        @(negedge clk);
        csr_if.mtvec_i      = 32'h0000_0300;
        csr_if.mstatus_ie_i = 1'b1;
        set_lines(3'b010, 3'b010);
        inst_pc_i    = 32'h0000_0070;
        inst_valid_i = 1'b1;
        sb.push_back('{4'd7, 1'b1, 32'h0000_0070, 32'h0000_0300});
        @(negedge clk);
        inst_valid_i = 1'b0;
        #1;
        e = sb.pop_front();
        checks++;
        if (csr_if.cause_we_o !== 1'b1 || csr_if.cause_o !== e.cause ||
            csr_if.epc_o !== e.epc) begin
            errors++;
            $display("FAIL rst_pre_save: we=%b cause=%0d epc=%h want 1 %0d %h",
                     csr_if.cause_we_o, csr_if.cause_o, csr_if.epc_o,
                     e.cause, e.epc);
        end
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        csr_if.mstatus_ie_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if ({stall_o, flush_o, redirect_o, redirect_pc_o,
                 csr_if.cause_we_o, csr_if.epc_we_o, csr_if.cause_o,
                 csr_if.interrupt_type_o, csr_if.epc_o,
                 csr_if.mstatus_ie_clear_o, csr_if.mstatus_ie_set_o} !== '0)
                begin
                errors++;
                $display("FAIL rst_mid_trap cycle %0d: stall=%b redir=%b pc=%h we=%b cause=%0d epc=%h want all 0",
                         c, stall_o, redirect_o, redirect_pc_o,
                         csr_if.cause_we_o, csr_if.cause_o, csr_if.epc_o);
            end
            @(negedge clk);
        end
        test_trap("post_rst", 32'h0000_0074, 32'h0000_0100,
                  3'b010, 3'b010, 1'b0, 1'b0, 4'd7, 1'b1, 32'h0000_0100);
    endtask

    initial begin
        test_reset();
        test_trap("timer_direct", 32'h0000_0040, 32'h0000_0100,
                  3'b010, 3'b010, 1'b0, 1'b0, 4'd7, 1'b1, 32'h0000_0100);
        test_trap("vec_ext", 32'h0000_0048, 32'h0000_0101,
                  3'b110, 3'b110, 1'b0, 1'b0, 4'd11, 1'b1, 32'h0000_012C);
        test_trap("vec_sw", 32'h0000_004C, 32'h0000_0101,
                  3'b011, 3'b011, 1'b0, 1'b0, 4'd3, 1'b1, 32'h0000_010C);
        test_trap("ecall", 32'h0000_0080, 32'h0000_0101,
                  3'b010, 3'b010, 1'b1, 1'b0, 4'd11, 1'b0, 32'h0000_0100);
        test_trap("ebreak", 32'h0000_008A, 32'h0000_0101,
                  3'b000, 3'b000, 1'b0, 1'b1, 4'd3, 1'b0, 32'h0000_0100);
        test_trap("mode11", 32'h0000_0090, 32'h0000_0203,
                  3'b010, 3'b010, 1'b0, 1'b0, 4'd7, 1'b1, 32'h0000_0200);
        test_trap("wrap", 32'h0000_0094, 32'hFFFF_FFF1,
                  3'b100, 3'b100, 1'b0, 1'b0, 4'd11, 1'b1, 32'h0000_001C);
        test_mret();
        test_masking();
        test_reset_mid_trap();
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/irq_trap_ctrl.md
Name: irq_trap_ctrl

Overview:
- Trap/interrupt sequencer for the M-mode-only core.
- Watches pending/enable state from csrfile and ecall/ebreak/mret decode from EX, then sequences the csrfile write strobes (mepc, mcause, mstatus MIE/MPIE).
- Stalls and flushes the pipeline and redirects fetch to the trap vector or to mepc.
- Sits beside csrfile; it is the only source of csrfile's cause_we/epc_we/ie_clear/ie_set inputs.

Parameters:
DATA_WIDTH, 32, PC/CSR data width

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
inst_valid_i  in  1  valid instruction at EX boundary this cycle
inst_pc_i  in  DATA_WIDTH  PC of that instruction
ecall_i  in  1  EX instruction is ecall
ebreak_i  in  1  EX instruction is ebreak
mret_i  in  1  EX instruction is mret
mip_external_i / mip_timer_i / mip_software_i  in  1 each  pending bits from csrfile
mie_external_i / mie_timer_i / mie_software_i  in  1 each  enable bits from csrfile
mstatus_ie_i  in  1  global MIE
mtvec_i  in  DATA_WIDTH  mtvec
epc_i  in  DATA_WIDTH  current mepc
stall_o  out  1  hold IF/ID/EX
flush_o  out  1  kill instructions in IF/ID/EX
redirect_o  out  1  load redirect_pc_o into PC
redirect_pc_o  out  DATA_WIDTH  new PC
cause_we_o  out  1  mcause write strobe
interrupt_type_o  out  1  mcause[31]
cause_o  out  4  mcause code
epc_we_o  out  1  mepc write strobe
epc_o  out  DATA_WIDTH  value for mepc
mstatus_ie_clear_o  out  1  trap entry: MPIE<=MIE, MIE<=0
mstatus_ie_set_o  out  1  mret: MIE<=MPIE, MPIE<=1

Behaviour:
- States: IDLE, TRAP_SAVE, TRAP_JUMP, MRET_RESTORE, MRET_JUMP. Reset: IDLE; all outputs 0; latched cause/epc/target registers 0.
- Event detection, IDLE only, requires inst_valid_i. Priority:
  - ecall: exception, cause 11.
  - ebreak: exception, cause 3.
  - mret.
  - Interrupt: mstatus_ie_i & (mip&mie), with external cause 11 > software cause 3 > timer cause 7; interrupt_type 1.
- Exceptions and mret are taken regardless of mstatus_ie_i.
- Detect cycle N (combinational, IDLE): stall_o=1, flush_o=1.
  - Trap: latch cause, type, epc=inst_pc_i, and target; next state TRAP_SAVE.
  - mret: next state MRET_RESTORE.
- Target (latched at N): base={mtvec_i[31:2],2'b00}.
  - mtvec_i[1:0]==01 and interrupt: base+{cause,2'b00}.
  - Otherwise: base. Modes 10/11 are treated as direct.
- TRAP_SAVE (N+1), one-cycle pulses: cause_we_o=1, epc_we_o=1, mstatus_ie_clear_o=1. epc_o=latched PC with [1:0]=00; cause_o and interrupt_type_o show the latched values. stall_o=1. Next state TRAP_JUMP.
- TRAP_JUMP (N+2): redirect_o=1, redirect_pc_o=target, stall_o=0. Next state IDLE.
- MRET_RESTORE (N+1): mstatus_ie_set_o=1, stall_o=1. Next state MRET_JUMP. This gives any preceding mepc write one cycle to land.
- MRET_JUMP (N+2): redirect_o=1, redirect_pc_o={epc_i[31:2],2'b00}, stall_o=0. Next state IDLE.
- Outside TRAP_SAVE, epc_o, cause_o and interrupt_type_o hold their last latched values; all strobes are 0.
- Inputs are ignored in every non-IDLE state; no nesting or queuing.
- Interrupts are level-sensitive. MIE is cleared at the end of N+1, so a still-pending line is not re-taken on return to IDLE.
- Synchronous reset in any state: IDLE and all outputs 0 after the edge, with no partial strobes afterwards.
- Adder arithmetic is DATA_WIDTH wide modulo 2^32.

Test Plan:
1. Timer interrupt, direct mode: mtvec=0x0000_0100, MIE=1, mie_timer=1, mip_timer=1, inst_pc=0x0000_0040.
   - N: flush_o=1, stall_o=1.
   - N+1: cause_we/epc_we/ie_clear=1, cause_o=7, interrupt_type_o=1, epc_o=0x40.
   - N+2: redirect_o=1, redirect_pc_o=0x100.
2. Vectored mode, external and timer both pending: mtvec=0x0000_0101 -> cause 11, redirect_pc_o=0x0000_012C.
3. ecall at pc 0x80 while timer pending, mtvec=0x0000_0101 -> cause_o=11, interrupt_type_o=0, epc_o=0x80, redirect_pc_o=0x100.
4. mret with epc_i=0x0000_0044:
   - N: stall_o=1, flush_o=1.
   - N+1: mstatus_ie_set_o=1.
   - N+2: redirect_o=1, redirect_pc_o=0x44.
5. Masking:
   - mip_timer=1, mie_timer=1, MIE=0 -> no strobes for 20 cycles.
   - mip_software=1, mie_software=0, MIE=1 -> likewise.
   - inst_valid_i=0 with interrupt enabled -> no take until valid.
6. Reset asserted in TRAP_SAVE cycle -> next cycle all outputs 0 and state IDLE; a following enabled timer interrupt runs the full 3-cycle sequence normally.
